// File: rtl/entropy_conditioner.sv
// Health-tested, von Neumann debiased byte source for the USB entropy generator.
// Raw LFSR bits are screened by RCT/APT, debiased in pairs and packed LSB-first into bytes.
module entropy_conditioner #(
    parameter int RCT_CUTOFF   = 32,
    parameter int APT_WINDOW   = 1024,
    parameter int APT_CUTOFF   = 600,
    parameter int STARTUP_BITS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        byte_valid,
    output logic [7:0]  byte_out,
    input  logic        byte_ack,
    output logic        running,
    output logic        health_fail,
    output logic [1:0]  fail_cause,
    output logic [15:0] dropped_count
);

    localparam int RW = $clog2(RCT_CUTOFF + 1);
    localparam int AW = $clog2(APT_WINDOW + 1);
    localparam int PW = $clog2(APT_WINDOW);
    localparam int WW = $clog2(STARTUP_BITS + 1);

    typedef enum logic [1:0] {WARMUP, RUN, FAILED} state_e;

    state_e        state_q;
    logic          have_prev_q;
    logic          prev_bit_q;
    logic [RW-1:0] rct_q;
    logic [PW-1:0] apt_pos_q;
    logic          apt_ref_q;
    logic [AW-1:0] apt_cnt_q;
    logic [WW-1:0] warm_q;
    logic          phase_q;
    logic          pair_first_q;
    logic [7:0]    pack_q;
    logic [2:0]    pack_cnt_q;
    logic [7:0]    byte_q;
    logic          valid_q;
    logic          running_q;
    logic          fail_q;
    logic [1:0]    cause_q;
    logic [15:0]   dropped_q;

    logic          strobe;
    logic [RW-1:0] rct_d;
    logic          apt_ref_d;
    logic [AW-1:0] apt_cnt_d;
    logic [PW-1:0] apt_pos_d;
    logic          rct_fail;
    logic          apt_fail;
    logic          dbit_valid;
    logic          can_load;
    logic [7:0]    full_byte;

    always_comb begin
        strobe    = bit_valid && (state_q != FAILED);
        rct_d     = (!have_prev_q || (bit_in != prev_bit_q)) ? RW'(1) : rct_q + RW'(1);
        apt_ref_d = (apt_pos_q == '0) ? bit_in : apt_ref_q;
        if (apt_pos_q == '0)
            apt_cnt_d = AW'(1);
        else if (bit_in == apt_ref_q)
            apt_cnt_d = apt_cnt_q + AW'(1);
        else
            apt_cnt_d = apt_cnt_q;
        apt_pos_d  = (apt_pos_q == PW'(APT_WINDOW - 1)) ? '0 : apt_pos_q + PW'(1);
        rct_fail   = rct_d >= RW'(RCT_CUTOFF);
        apt_fail   = apt_cnt_d >= AW'(APT_CUTOFF);
        // A pair is complete on the second bit; 01 -> 0 and 10 -> 1, i.e. the first bit.
        dbit_valid = (state_q == RUN) && phase_q && (pair_first_q != bit_in);
        full_byte  = {pair_first_q, pack_q[6:0]};
        can_load   = !valid_q || byte_ack;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WARMUP;
            have_prev_q  <= 1'b0;
            prev_bit_q   <= 1'b0;
            rct_q        <= '0;
            apt_pos_q    <= '0;
            apt_ref_q    <= 1'b0;
            apt_cnt_q    <= '0;
            warm_q       <= '0;
            phase_q      <= 1'b0;
            pair_first_q <= 1'b0;
            pack_q       <= '0;
            pack_cnt_q   <= '0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            running_q    <= 1'b0;
            fail_q       <= 1'b0;
            cause_q      <= '0;
            dropped_q    <= '0;
        end else begin
            if (valid_q && byte_ack)
                valid_q <= 1'b0;
            if (strobe) begin
                have_prev_q <= 1'b1;
                prev_bit_q  <= bit_in;
                rct_q       <= rct_d;
                apt_pos_q   <= apt_pos_d;
                apt_ref_q   <= apt_ref_d;
                apt_cnt_q   <= apt_cnt_d;
                if (rct_fail || apt_fail) begin
                    // The failing bit never reaches the extractor; all pending output is discarded.
                    state_q    <= FAILED;
                    running_q  <= 1'b0;
                    fail_q     <= 1'b1;
                    cause_q    <= {apt_fail, rct_fail};
                    valid_q    <= 1'b0;
                    byte_q     <= '0;
                    pack_q     <= '0;
                    pack_cnt_q <= '0;
                    phase_q    <= 1'b0;
                end else if (state_q == WARMUP) begin
                    warm_q <= warm_q + WW'(1);
                    if (warm_q == WW'(STARTUP_BITS - 1)) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        phase_q   <= 1'b0;
                    end
                end else begin
                    phase_q <= !phase_q;
                    if (!phase_q)
                        pair_first_q <= bit_in;
                    if (dbit_valid) begin
                        if (pack_cnt_q == 3'd7) begin
                            pack_q     <= '0;
                            pack_cnt_q <= '0;
                            if (can_load) begin
                                byte_q  <= full_byte;
                                valid_q <= 1'b1;
                            end else if (dropped_q != 16'hFFFF) begin
                                dropped_q <= dropped_q + 16'd1;
                            end
                        end else begin
                            pack_q[pack_cnt_q] <= pair_first_q;
                            pack_cnt_q         <= pack_cnt_q + 3'd1;
                        end
                    end
                end
            end
        end
    end

    assign byte_valid    = valid_q;
    assign byte_out      = byte_q;
    assign running       = running_q;
    assign health_fail   = fail_q;
    assign fail_cause    = cause_q;
    assign dropped_count = dropped_q;

endmodule
